load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage consumer of the EX/MEM register. Turns a load/store (addr, rs2 data, funct3) into one
//  valid/ready transaction on a variable-latency data bus. Does byte-lane steering and load sign/zero
//  extension for LB/LH/LW/LBU/LHU/SB/SH/SW. Holds `stall` high until the access completes.
//  `stall` freezes PC, IF/ID, ID/EX and EX/MEM, and inserts a bubble into MEM/WB.
// PARAMETERS
//  RSP_TIMEOUT  255  max cycles waiting for bus_rsp_valid after the request handshake; 0 = no timeout
// PORTS
//  clk            in   1   core clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  req_read       in   1   EX/MEM mem_read
//  req_write      in   1   EX/MEM mem_write (never asserted together with req_read)
//  req_funct3     in   3   EX/MEM funct3 (access size and sign)
//  req_addr       in   32  EX/MEM alu_result (byte address)
//  req_wdata      in   32  EX/MEM rs2 data
//  stall          out  1   access in progress; pipeline must hold the req_* inputs stable
//  load_data      out  32  extended load result; valid in the cycle stall falls
//  bus_err        out  1   1-cycle pulse when the response times out
//  misalign_err   out  1   1-cycle pulse on a misaligned access (LSU_MISALIGN_TRAP_EN only; else tied 0)
//  bus_req_valid  out  1   request valid
//  bus_req_ready  in   1   request accepted when valid && ready
//  bus_req_we     out  1   1 = write
//  bus_req_addr   out  32  word-aligned address {req_addr[31:2],2'b00}
//  bus_req_be     out  4   byte enables
//  bus_req_wdata  out  32  lane-replicated write data
//  bus_rsp_valid  in   1   response/ack; at most one outstanding
//  bus_rsp_rdata  in   32  read word (ignored on writes)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including load_data, bus_req_*, and both err pulses.
//  FSM: IDLE -> REQ -> RSP -> DONE -> IDLE.
//   IDLE: access = req_read|req_write. If access: stall=1 (combinational), latch the request, go to REQ.
//   REQ:  bus_req_valid=1 with registered fields, stable until ready. On valid&&ready go to RSP.
//   RSP:  wait for bus_rsp_valid. Timeout counter starts at 0 on entry.
//         On rsp: register the extended rdata into load_data, go to DONE.
//         On count==RSP_TIMEOUT-1 (when RSP_TIMEOUT!=0): bus_err=1, load_data=0, go to DONE.
//         bus_req_valid=0.
//   DONE: stall=0. The pipeline advances at this edge. Next state IDLE; IDLE does not re-issue the completed access.
//  stall = (IDLE&&access) | REQ | RSP. Zero-wait bus (ready=1, rsp next cycle) gives 3 stall cycles.
//  Stores also wait in RSP for bus_rsp_valid (write ack). load_data is unchanged on a store.
//  Lanes, with o=req_addr[1:0]:
//   SB: be=4'b0001<<o, wdata={4{b}}
//   SH: be = addr[1] ? 1100 : 0011, wdata={2{h}}
//   SW and funct3 values 3/6/7: be=1111, treated as word
//  Load extract: byte at lane o, half at lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
//  A bus_rsp_valid that arrives in IDLE, REQ or DONE is ignored.
//  Reset asserted mid-access returns the FSM to IDLE immediately and drops bus_req_valid.
//   A late response after reset is ignored.
//  The timeout counter saturates; its width is $clog2(RSP_TIMEOUT+1).
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: an access is misaligned when it is LH/LHU/SH with addr[0]=1,
//   or LW/SW with addr[1:0]!=0. A misaligned access goes IDLE -> DONE directly: 1 stall cycle, no bus request,
//   misalign_err=1 in DONE, load_data=0, no write.
//  LSU_MISALIGN_TRAP_EN undefined: low address bits are force-aligned (half: addr[0] ignored;
//   word: addr[1:0] ignored) and the access proceeds normally. misalign_err is tied 0.
// STRUCTURE
//  Package lsu_pkg holds the funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2)
//   and the FSM state encodings.
//  Sub-module lsu_lane_align: combinational. Computes be and wdata from the store path,
//   and extends rdata on the load path. Instantiated once.
//  Top level holds the FSM, request latch, timeout counter and load_data register.
// TESTING
//  1. LW 0x100 with ready=1 and rsp 1 cycle later carrying 0xDEADBEEF
//     -> stall high 3 cycles, then load_data=0xDEADBEEF, exactly one request.
//  2. LB 0x103 with rdata 0x80112233 -> be=4'b1111 on read, load_data=0xFFFFFF80.
//     Same access as LBU -> 0x00000080.
//  3. SH 0x102 with wdata 0x0000ABCD -> be=4'b1100, bus_req_wdata=0xABCDABCD.
//     ready held low 4 cycles -> valid and fields stable throughout, stall held.
//  4. RSP_TIMEOUT=8 and no response -> bus_err pulse exactly 8 cycles after the handshake,
//     load_data=0, FSM back in IDLE.
//  5. Back-to-back SW then LW (req_* change in the cycle after DONE) -> two distinct requests, no duplicate.
//     Assert rst_n low during RSP -> valid=0, stall=0 next cycle.
//  6. With LSU_MISALIGN_TRAP_EN: LW 0x101 -> no bus_req_valid, misalign_err 1 cycle, stall 1 cycle.
//     Without the macro: same access -> bus_req_addr=0x100, be=1111.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 encodings, FSM states, bus request payload.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Access size lives in funct3[1:0]; funct3[2] selects unsigned loads
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } lsu_bus_req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores (byte enables, replicated data) and load sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [BE_W-1:0] be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] rdata_c
);

    // Store path: reads always fetch the full word
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        if (we) begin
            case (funct3[1:0])
                SZ_BYTE: begin
                    be_c    = 4'b0001 << addr_lo;
                    wdata_c = {4{wdata[7:0]}};
                end
                SZ_HALF: begin
                    be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load path: addr_lo[0] is ignored for halves, so misaligned halves are force-aligned
    always_comb begin
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v  = rdata[{addr_lo, 3'b000} +: 8];
        half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        rdata_c = rdata;
        case (funct3)
            F3_LB:   rdata_c = {{24{byte_v[7]}}, byte_v};
            F3_LH:   rdata_c = {{16{half_v[15]}}, half_v};
            F3_LBU:  rdata_c = {24'h000000, byte_v};
            F3_LHU:  rdata_c = {16'h0000, half_v};
            default: rdata_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one valid/ready bus transaction per access, stall until complete.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        bus_err,
    output logic        misalign_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [3:0]  bus_req_be,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata
);

    localparam int unsigned CNT_W = (RSP_TIMEOUT == 0) ? 1 : $clog2(RSP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX =
        (RSP_TIMEOUT == 0) ? {CNT_W{1'b1}} : CNT_W'(RSP_TIMEOUT);

    logic [1:0]       state_q, state_nxt;
    lsu_bus_req_t     req_q;
    logic             valid_q;
    logic [2:0]       lat_funct3;
    logic [1:0]       lat_addr_lo;
    logic [CNT_W-1:0] rsp_cnt;
    logic [31:0]      load_data_q;
    logic             bus_err_q;

    logic             access_c;
    logic             misalign_c;
    logic             timeout_c;
    logic [2:0]       align_funct3;
    logic [1:0]       align_addr_lo;
    logic [3:0]       align_be;
    logic [31:0]      align_wdata;
    logic [31:0]      align_rdata;

    assign access_c  = req_read | req_write;
    assign timeout_c = (RSP_TIMEOUT != 0) && (rsp_cnt == CNT_W'(RSP_TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign misalign_c = ((req_funct3[1:0] == SZ_HALF) && req_addr[0]) ||
                        ((req_funct3 == F3_LW) && (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= (state_q == ST_IDLE) && access_c && misalign_c;
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_c   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Store lanes come from the live request in IDLE; load extraction uses the latched request
    assign align_funct3  = (state_q == ST_IDLE) ? req_funct3    : lat_funct3;
    assign align_addr_lo = (state_q == ST_IDLE) ? req_addr[1:0] : lat_addr_lo;

    lsu_lane_align u_lane_align (
        .funct3  (align_funct3),
        .addr_lo (align_addr_lo),
        .we      (req_write),
        .wdata   (req_wdata),
        .rdata   (bus_rsp_rdata),
        .be_c    (align_be),
        .wdata_c (align_wdata),
        .rdata_c (align_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        stall     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_c) begin
                    stall     = 1'b1;
                    state_nxt = misalign_c ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus_req_ready) state_nxt = ST_RSP;
            end
            ST_RSP: begin
                stall = 1'b1;
                if (bus_rsp_valid || timeout_c) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, bus request register, load result and timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            valid_q     <= 1'b0;
            lat_funct3  <= 3'd0;
            lat_addr_lo <= 2'd0;
            load_data_q <= 32'd0;
            bus_err_q   <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            if ((state_q == ST_IDLE) && access_c) begin
                lat_funct3  <= req_funct3;
                lat_addr_lo <= req_addr[1:0];
                if (misalign_c) begin
                    load_data_q <= 32'd0;
                end else begin
                    req_q.we    <= req_write;
                    req_q.addr  <= {req_addr[31:2], 2'b00};
                    req_q.be    <= align_be;
                    req_q.wdata <= align_wdata;
                    valid_q     <= 1'b1;
                end
            end
            if ((state_q == ST_REQ) && bus_req_ready) valid_q <= 1'b0;
            if (state_q == ST_RSP) begin
                if (bus_rsp_valid) begin
                    if (!req_q.we) load_data_q <= align_rdata;
                end else if (timeout_c) begin
                    bus_err_q   <= 1'b1;
                    load_data_q <= 32'd0;
                end
            end
        end
    end

    // Response wait counter: cleared outside RSP, saturating inside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 rsp_cnt <= '0;
        else if (state_q != ST_RSP) rsp_cnt <= '0;
        else if (rsp_cnt != CNT_MAX) rsp_cnt <= rsp_cnt + CNT_W'(1);
    end

    assign load_data     = load_data_q;
    assign bus_err       = bus_err_q;
    assign bus_req_valid = valid_q;
    assign bus_req_we    = req_q.we;
    assign bus_req_addr  = req_q.addr;
    assign bus_req_be    = req_q.be;
    assign bus_req_wdata = req_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (RSP_TIMEOUT=8).
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_read, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        bus_err, misalign_err;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_be;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    int checks = 0;
    int passed = 0;

    load_store_unit #(.RSP_TIMEOUT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .stall         (stall),
        .load_data     (load_data),
        .bus_err       (bus_err),
        .misalign_err  (misalign_err),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_we    (bus_req_we),
        .bus_req_addr  (bus_req_addr),
        .bus_req_be    (bus_req_be),
        .bus_req_wdata (bus_req_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          stall_cycles;
        int          nreq;
        int          valid_cycles;
        int          err_pulses;
        int          err_edges;
        int          mis_pulses;
        logic        unstable;
        logic        done;
        logic [31:0] ld;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    // Bus-side driver for one access; returns what was observed, starts and ends at posedge+1
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int ready_lo, input int rsp_dly, output acc_t r);
        int rdy_left, rsp_wait, hs_cyc, err_cyc;
        logic raise_rdy;
        r = '{default: 0};
        rdy_left = ready_lo; rsp_wait = 0; hs_cyc = -1; err_cyc = -1;
        req_read = !we; req_write = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        bus_req_ready = (ready_lo == 0); bus_rsp_valid = 1'b0; bus_rsp_rdata = rdata;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            raise_rdy = 1'b0;
            if (stall) r.stall_cycles++;
            if (bus_err) begin r.err_pulses++; err_cyc = cyc; end
            if (misalign_err) r.mis_pulses++;
            if (bus_req_valid) begin
                if (r.valid_cycles == 0) begin
                    r.we = bus_req_we; r.addr = bus_req_addr; r.be = bus_req_be; r.wdata = bus_req_wdata;
                end else if (r.we !== bus_req_we || r.addr !== bus_req_addr ||
                             r.be !== bus_req_be || r.wdata !== bus_req_wdata) begin
                    r.unstable = 1'b1;
                end
                r.valid_cycles++;
                if (bus_req_ready) begin
                    r.nreq++; hs_cyc = cyc; rsp_wait = rsp_dly;
                end else begin
                    rdy_left--;
                    if (rdy_left <= 0) raise_rdy = 1'b1;
                end
            end
            if (!stall) begin r.done = 1'b1; r.ld = load_data; end
            @(posedge clk); #1;
            if (r.done) break;
            if (raise_rdy) bus_req_ready = 1'b1;
            if (rsp_wait > 0) begin
                rsp_wait--;
                bus_rsp_valid = (rsp_wait == 0);
            end else begin
                bus_rsp_valid = 1'b0;
            end
        end
        r.err_edges = (err_cyc >= 0 && hs_cyc >= 0) ? err_cyc - hs_cyc - 1 : -1;
        req_read = 1'b0; req_write = 1'b0; bus_rsp_valid = 1'b0; bus_req_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_read = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({stall, bus_err, misalign_err, bus_req_valid, bus_req_we} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {stall, bus_err, misalign_err, bus_req_valid, bus_req_we});
        else passed++;
        checks++;
        if ({load_data, bus_req_addr, bus_req_wdata, bus_req_be} !== 100'd0)
            $display("FAIL reset_data: ld=%h addr=%h wd=%h be=%b want all 0", load_data, bus_req_addr, bus_req_wdata, bus_req_be);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1; bus_req_ready = 1'b1;
    endtask

    task automatic test_lw_zero_wait();
        acc_t r;
        do_access(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1, r);
        checks++;
        if (r.stall_cycles !== 3) $display("FAIL lw_stall: got %0d want 3", r.stall_cycles); else passed++;
        checks++;
        if (r.nreq !== 1 || r.valid_cycles !== 1) $display("FAIL lw_nreq: got %0d/%0d want 1/1", r.nreq, r.valid_cycles); else passed++;
        checks++;
        if (r.ld !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want deadbeef", r.ld); else passed++;
        checks++;
        if (r.we !== 1'b0 || r.addr !== 32'h100 || r.be !== 4'b1111)
            $display("FAIL lw_fields: got we=%b addr=%h be=%b want 0 00000100 1111", r.we, r.addr, r.be);
        else passed++;
    endtask

    task automatic test_lb_lbu();
        acc_t r;
        do_access(1'b0, 3'd0, 32'h103, 32'd0, 32'h80112233, 0, 1, r);
        checks++;
        if (r.be !== 4'b1111 || r.addr !== 32'h100) $display("FAIL lb_fields: got be=%b addr=%h want 1111 00000100", r.be, r.addr); else passed++;
        checks++;
        if (r.ld !== 32'hFFFFFF80) $display("FAIL lb_data: got %h want ffffff80", r.ld); else passed++;
        do_access(1'b0, 3'd4, 32'h103, 32'd0, 32'h80112233, 0, 1, r);
        checks++;
        if (r.ld !== 32'h00000080) $display("FAIL lbu_data: got %h want 00000080", r.ld); else passed++;
    endtask

    task automatic test_sh_backpressure();
        acc_t r;
        do_access(1'b1, 3'd1, 32'h102, 32'h0000ABCD, 32'h11111111, 4, 1, r);
        checks++;
        if (r.we !== 1'b1 || r.be !== 4'b1100 || r.addr !== 32'h100)
            $display("FAIL sh_fields: got we=%b be=%b addr=%h want 1 1100 00000100", r.we, r.be, r.addr);
        else passed++;
        checks++;
        if (r.wdata !== 32'hABCDABCD) $display("FAIL sh_wdata: got %h want abcdabcd", r.wdata); else passed++;
        checks++;
        if (r.unstable !== 1'b0 || r.valid_cycles !== 5 || r.nreq !== 1)
            $display("FAIL sh_hold: got unstable=%b valid=%0d nreq=%0d want 0 5 1", r.unstable, r.valid_cycles, r.nreq);
        else passed++;
        checks++;
        if (r.stall_cycles !== 7) $display("FAIL sh_stall: got %0d want 7", r.stall_cycles); else passed++;
        checks++;
        if (r.ld !== 32'h00000080) $display("FAIL sh_ld_kept: got %h want 00000080", r.ld); else passed++;
    endtask

    task automatic test_timeout();
        acc_t r;
        do_access(1'b0, 3'd2, 32'h200, 32'd0, 32'h0, 0, 0, r);
        checks++;
        if (r.done !== 1'b1 || r.err_pulses !== 1) $display("FAIL to_pulse: got done=%b pulses=%0d want 1 1", r.done, r.err_pulses); else passed++;
        checks++;
        if (r.err_edges !== 8) $display("FAIL to_latency: got %0d want 8", r.err_edges); else passed++;
        checks++;
        if (r.ld !== 32'd0 || r.stall_cycles !== 10) $display("FAIL to_data: got ld=%h stall=%0d want 0 10", r.ld, r.stall_cycles); else passed++;
        @(negedge clk);
        checks++;
        if ({stall, bus_req_valid, bus_err} !== 3'b000) $display("FAIL to_idle: got %b want 000", {stall, bus_req_valid, bus_err}); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        acc_t r1, r2;
        do_access(1'b1, 3'd2, 32'h300, 32'h12345678, 32'h0, 0, 1, r1);
        do_access(1'b0, 3'd2, 32'h304, 32'd0, 32'hCAFEF00D, 0, 1, r2);
        checks++;
        if (r1.nreq !== 1 || r2.nreq !== 1) $display("FAIL b2b_nreq: got %0d %0d want 1 1", r1.nreq, r2.nreq); else passed++;
        checks++;
        if (r1.we !== 1'b1 || r1.addr !== 32'h300 || r1.be !== 4'b1111 || r1.wdata !== 32'h12345678)
            $display("FAIL b2b_sw: got we=%b addr=%h be=%b wd=%h", r1.we, r1.addr, r1.be, r1.wdata);
        else passed++;
        checks++;
        if (r2.we !== 1'b0 || r2.addr !== 32'h304 || r2.ld !== 32'hCAFEF00D)
            $display("FAIL b2b_lw: got we=%b addr=%h ld=%h want 0 00000304 cafef00d", r2.we, r2.addr, r2.ld);
        else passed++;
    endtask

    task automatic test_reset_mid_access();
        acc_t r;
        req_read = 1'b1; req_funct3 = 3'd2; req_addr = 32'h400; bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h55555555;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || bus_req_valid !== 1'b0) $display("FAIL rst_pre: got stall=%b valid=%b want 1 0", stall, bus_req_valid); else passed++;
        #2 rst_n = 1'b0; req_read = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || bus_req_valid !== 1'b0) $display("FAIL rst_mid: got stall=%b valid=%b want 0 0", stall, bus_req_valid); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1; bus_rsp_valid = 1'b1;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || bus_req_valid !== 1'b0 || load_data !== 32'd0)
            $display("FAIL rst_late_rsp: got stall=%b valid=%b ld=%h want 0 0 0", stall, bus_req_valid, load_data);
        else passed++;
        @(posedge clk); #1;
        do_access(1'b0, 3'd2, 32'h408, 32'd0, 32'h13579BDF, 0, 1, r);
        checks++;
        if (r.ld !== 32'h13579BDF || r.stall_cycles !== 3) $display("FAIL rst_recover: got ld=%h stall=%0d want 13579bdf 3", r.ld, r.stall_cycles); else passed++;
    endtask

    task automatic test_misalign();
        acc_t r;
        do_access(1'b0, 3'd2, 32'h101, 32'd0, 32'h0BADF00D, 0, 1, r);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (r.valid_cycles !== 0 || r.mis_pulses !== 1) $display("FAIL mis_trap: got valid=%0d mis=%0d want 0 1", r.valid_cycles, r.mis_pulses); else passed++;
        checks++;
        if (r.stall_cycles !== 1 || r.ld !== 32'd0) $display("FAIL mis_stall: got stall=%0d ld=%h want 1 0", r.stall_cycles, r.ld); else passed++;
`else
        checks++;
        if (r.addr !== 32'h100 || r.be !== 4'b1111 || r.nreq !== 1) $display("FAIL mis_align: got addr=%h be=%b nreq=%0d want 00000100 1111 1", r.addr, r.be, r.nreq); else passed++;
        checks++;
        if (r.ld !== 32'h0BADF00D || r.mis_pulses !== 0) $display("FAIL mis_data: got ld=%h mis=%0d want 0badf00d 0", r.ld, r.mis_pulses); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_lb_lbu();
        test_sh_backpressure();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_misalign();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
